// File: rtl/memory_mapped_io_bank_if.sv
// Word-wide bus port shared by the CPU and GPU sides of memory_mapped_io_bank.
// The master drives address/write strobes; the slave returns registered read data.
interface memory_mapped_io_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] read_data;

  modport master (
    output address,
    output write_data,
    output write_enable,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  write_enable,
    output read_data
  );
endinterface

// File: rtl/memory_mapped_io_bank.sv
// Dual-port word RAM shared by CPU and GPU, plus a bank of IO channels mapped at the
// top of the CPU address space (synchronised inputs, sticky change flags, outputs, irq).
module memory_mapped_io_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_DEPTH  = 1024,
  parameter int CHANNELS   = 2,
  parameter int IO_WIDTH   = 8
) (
  input  logic                         clock_i,
  input  logic                         reset_ni,
  memory_mapped_io_bank_if.slave       cpu_bus,
  memory_mapped_io_bank_if.slave       gpu_bus,
  input  logic [CHANNELS*IO_WIDTH-1:0] io_in_i,
  output logic [CHANNELS*IO_WIDTH-1:0] io_out_o,
  output logic                         irq_o
);

  localparam int IO_BASE = (1 << ADDR_WIDTH) - 2 * CHANNELS;
  localparam int RAM_AW  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);
  localparam logic [ADDR_WIDTH:0]   RAM_TOP   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              cpu_is_ram;
  logic              cpu_is_io;
  logic              cpu_is_status;
  logic              gpu_is_ram;
  logic [CH_W:0]     cpu_io_off;
  logic [CH_W-1:0]   cpu_ch;
  logic              cpu_ram_we;
  logic              gpu_ram_we;
  logic              cpu_io_we;
  logic [RAM_AW-1:0] cpu_ram_addr;
  logic [RAM_AW-1:0] gpu_ram_addr;

  // The IO window is exactly 2*CHANNELS words, so only the low offset bits matter.
  always_comb begin
    cpu_is_ram    = ({1'b0, cpu_bus.address} < RAM_TOP);
    cpu_is_io     = (cpu_bus.address >= IO_BASE_A);
    cpu_io_off    = cpu_bus.address[CH_W:0] - IO_BASE_A[CH_W:0];
    cpu_ch        = cpu_io_off[CH_W:1];
    cpu_is_status = cpu_io_off[0];
    gpu_is_ram    = ({1'b0, gpu_bus.address} < RAM_TOP);
    cpu_ram_addr  = cpu_bus.address[RAM_AW-1:0];
    gpu_ram_addr  = gpu_bus.address[RAM_AW-1:0];
    cpu_ram_we    = cpu_bus.write_enable & cpu_is_ram & reset_ni;
    gpu_ram_we    = gpu_bus.write_enable & gpu_is_ram & reset_ni;
    cpu_io_we     = cpu_bus.write_enable & cpu_is_io;
  end

  // ---------------------------------------------------------------------------
  // Shared RAM: read-first on both ports, CPU write ordered last so it wins a
  // same-address collision. Contents are deliberately not reset.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ram_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] cpu_ram_rd_q;
  logic [DATA_WIDTH-1:0] gpu_ram_rd_q;

  always_ff @(posedge clock_i) begin
    if (gpu_ram_we) begin
      ram_mem[gpu_ram_addr] <= gpu_bus.write_data;
    end
    if (cpu_ram_we) begin
      ram_mem[cpu_ram_addr] <= cpu_bus.write_data;
    end
    cpu_ram_rd_q <= ram_mem[cpu_ram_addr];
    gpu_ram_rd_q <= ram_mem[gpu_ram_addr];
  end

  // ---------------------------------------------------------------------------
  // IO channels
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ch_data   [CHANNELS];
  logic [DATA_WIDTH-1:0] ch_status [CHANNELS];
  logic [CHANNELS-1:0]   ch_irq;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [IO_WIDTH-1:0] sync1_q;
      logic [IO_WIDTH-1:0] sync2_q;
      logic [IO_WIDTH-1:0] prev_q;
      logic [IO_WIDTH-1:0] out_q;
      logic [IO_WIDTH-1:0] out_d;
      logic                changed_q;
      logic                changed_d;
      logic                irq_en_q;
      logic                irq_en_d;
      logic                sel;
      logic                wr_data;
      logic                wr_status;

      assign sel       = cpu_io_we & (cpu_ch == CH_W'(gi));
      assign wr_data   = sel & ~cpu_is_status;
      assign wr_status = sel & cpu_is_status;

      // A change seen this cycle outranks a write-one-to-clear in the same cycle.
      always_comb begin
        out_d     = out_q;
        irq_en_d  = irq_en_q;
        changed_d = changed_q;
        if (wr_data) begin
          out_d = cpu_bus.write_data[IO_WIDTH-1:0];
        end
        if (wr_status) begin
          irq_en_d = cpu_bus.write_data[1];
          if (cpu_bus.write_data[0]) begin
            changed_d = 1'b0;
          end
        end
        if (sync2_q != prev_q) begin
          changed_d = 1'b1;
        end
      end

      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          sync1_q   <= '0;
          sync2_q   <= '0;
          prev_q    <= '0;
          out_q     <= '0;
          changed_q <= 1'b0;
          irq_en_q  <= 1'b0;
        end else begin
          sync1_q   <= io_in_i[gi*IO_WIDTH +: IO_WIDTH];
          sync2_q   <= sync1_q;
          prev_q    <= sync2_q;
          out_q     <= out_d;
          changed_q <= changed_d;
          irq_en_q  <= irq_en_d;
        end
      end

      assign io_out_o[gi*IO_WIDTH +: IO_WIDTH] = out_q;
      assign ch_data[gi]   = DATA_WIDTH'(sync2_q);
      assign ch_status[gi] = DATA_WIDTH'({irq_en_q, changed_q});
      assign ch_irq[gi]    = changed_q & irq_en_q;
    end
  endgenerate

  assign irq_o = |ch_irq;

  // ---------------------------------------------------------------------------
  // Registered read path. The select flops gate the unreset RAM read registers,
  // so both ports present zero as soon as reset asserts.
  // ---------------------------------------------------------------------------
  logic                  cpu_sel_ram_q;
  logic                  cpu_sel_ram_d;
  logic                  gpu_sel_ram_q;
  logic                  gpu_sel_ram_d;
  logic [DATA_WIDTH-1:0] cpu_io_rd_q;
  logic [DATA_WIDTH-1:0] cpu_io_rd_d;

  always_comb begin
    cpu_sel_ram_d = cpu_is_ram;
    gpu_sel_ram_d = gpu_is_ram;
    cpu_io_rd_d   = '0;
    if (cpu_is_io) begin
      cpu_io_rd_d = cpu_is_status ? ch_status[cpu_ch] : ch_data[cpu_ch];
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cpu_sel_ram_q <= 1'b0;
      gpu_sel_ram_q <= 1'b0;
      cpu_io_rd_q   <= '0;
    end else begin
      cpu_sel_ram_q <= cpu_sel_ram_d;
      gpu_sel_ram_q <= gpu_sel_ram_d;
      cpu_io_rd_q   <= cpu_io_rd_d;
    end
  end

  assign cpu_bus.read_data = cpu_sel_ram_q ? cpu_ram_rd_q : cpu_io_rd_q;
  assign gpu_bus.read_data = gpu_sel_ram_q ? gpu_ram_rd_q : '0;

endmodule

// File: doc/memory_mapped_io_bank.md
# memory_mapped_io_bank

Parametrised successor to the CPU/GPU memory-and-IO block. It provides a dual-port word RAM in low address space for the CPU and GPU, and a bank of IO channels mapped at the top of the CPU address space. Each channel has a synchronised input with sticky change detection, a writable output register and a per-channel interrupt enable. The block sits between the CPU/GPU bus ports and the board pins (switches, LEDs).

## Interface
- DATA_WIDTH, 16, word width of both ports
- ADDR_WIDTH, 16, address width of both ports
- RAM_DEPTH, 1024, RAM words at addresses 0..RAM_DEPTH-1; must be ≤ IO_BASE
- CHANNELS, 2, number of IO channels (1..8)
- IO_WIDTH, 8, bits per channel; must be ≤ DATA_WIDTH
- Derived: IO_BASE = 2^ADDR_WIDTH − 2·CHANNELS (default 65532)

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_address  in  ADDR_WIDTH  CPU word address
- cpu_write_data  in  DATA_WIDTH  CPU write data
- cpu_write_enable  in  1  CPU write strobe
- cpu_read_data  out  DATA_WIDTH  registered CPU read data
- gpu_address  in  ADDR_WIDTH  GPU word address
- gpu_write_data  in  DATA_WIDTH  GPU write data
- gpu_write_enable  in  1  GPU write strobe
- gpu_read_data  out  DATA_WIDTH  registered GPU read data
- io_in  in  CHANNELS·IO_WIDTH  asynchronous pin inputs; channel i occupies bits [i·IO_WIDTH +: IO_WIDTH]
- io_out  out  CHANNELS·IO_WIDTH  output registers, same packing
- irq  out  1  OR over channels of (changed & irq_en)

## Operation
- Address map for each port:
  - 0..RAM_DEPTH−1: RAM.
  - RAM_DEPTH..IO_BASE−1: hole; reads return 0, writes are ignored.
  - IO_BASE+2i: channel i DATA.
  - IO_BASE+2i+1: channel i STATUS.
- DATA register:
  - Read returns the synchronised input value, zero-extended.
  - Write loads io_out[i] from write_data[IO_WIDTH−1:0].
- STATUS register:
  - Read returns {0…, irq_en, changed}.
  - Write: bit1 loads irq_en; bit0 = 1 clears changed; bit0 = 0 leaves it unchanged.
- The GPU port sees only RAM. GPU reads of IO addresses or the hole return 0. GPU writes outside RAM are ignored.
- Input path per channel: io_in → sync1 → sync2 → prev. Whenever sync2 ≠ prev, changed is set.
- Simultaneous set and clear of changed in the same cycle: set wins.
- RAM collisions:
  - Both ports write the same address in the same cycle: CPU data is stored.
  - Read-during-write, same port or cross-port, same address: the read returns old data (read-first).
- RAM contents are not reset.
- Reset (reset = 0), applied immediately and asynchronously, forces to 0: io_out, sync1, sync2, prev, changed, irq_en, cpu_read_data, gpu_read_data and irq. This holds for reset mid-operation too; any write in that cycle is lost.

## Timing
- Read latency is 1 cycle for every region. The address presented before edge k gives read data valid after edge k, held until the next edge.
- Writes take effect at the edge where write_enable is sampled high. A same-cycle read of the same location returns pre-write data.
- Input latency for an io_in change that is stable before edge 0:
  - sync1 updates at edge 0, sync2 at edge 1, and changed is set at edge 2.
  - irq rises after edge 2 if irq_en = 1.
  - A DATA read issued in the cycle after edge 1 returns the new value.
- irq is derived from registers only, with no combinational path from inputs. It falls after the edge that clears the last enabled flag or clears irq_en.
- Input glitches shorter than one clock period may be missed. No debouncing is performed.

## Test plan
- Reset and IO defaults:
  - Hold reset low → all outputs 0.
  - After release, a CPU read at 65533 returns 0x0000 and a read at 65532 returns 0x0000 (io_in = 0).
- RAM both ports:
  - CPU writes 0xBEEF to address 5, GPU writes 0x1234 to address 6.
  - A CPU read of 6 returns 0x1234 one cycle later; a GPU read of 5 returns 0xBEEF.
  - Same-address writes (CPU 0xAAAA, GPU 0x5555 to address 7) → 0xAAAA is stored.
- Input sync and interrupt:
  - CPU writes 0x0002 to 65533 (irq_en = 1), then io_in[7:0] = 0x45.
  - irq rises after the 3rd edge; a read of 65532 returns 0x0045 and a read of 65533 returns 0x0003.
  - Write 0x0003 to 65533 → irq falls after the next edge; the read returns 0x0002.
- Set-beats-clear: io_in changes so that the flag-set edge coincides with a W1C write → changed stays 1.
- Output and hole:
  - CPU writes 0x00A5 to 65534 → io_out[15:8] = 0xA5 after the edge.
  - A GPU write to 65534 leaves io_out unchanged.
  - CPU reads of 2000 and 65000 return 0.
- Mid-operation reset: assert reset low in the cycle of a CPU write to 65532 with irq pending → io_out = 0, irq = 0 immediately, and the write has no effect.
